dmem_arbiter: RTL

- Shares the single-port data memory between two requesters: port 0 is the CPU load/store unit, port 1 is the debug/DMA loader.
- Each requester uses a req/ack handshake. The block serialises the transactions, drives the memory's ena/wsignal/rsignal/addr/wdata, captures read data and flags out-of-range addresses.
- It sits between the CPU datapath and the data memory instance.

---
 rtl/dmem_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the single-port data memory.
// Each transaction runs IDLE -> ACCESS -> DONE; out-of-range accesses are suppressed.
module dmem_arbiter #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              ack0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata,
   output logic              err,
   output logic              busy,
   output logic              mem_ena,
   output logic              mem_wsignal,
   output logic              mem_rsignal,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t state, state_nx;

   logic              sel;
   logic              we_l;
   logic              oor;
   logic              last_grant;
   logic [ADDR_W-1:0] addr_l;
   logic [DATA_W-1:0] wdata_l;

   logic              grant;
   logic              gsel;
   logic [ADDR_W-1:0] gaddr;

   // On a tie, the port that did not win last time is served.
   assign grant = req0 | req1;
   assign gsel  = (req0 & req1) ? ~last_grant : req1;
   assign gaddr = gsel ? addr1 : addr0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (grant) state_nx = ACCESS;
         ACCESS:  state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel        <= 1'b0;
         we_l       <= 1'b0;
         oor        <= 1'b0;
         last_grant <= 1'b1;
         addr_l     <= '0;
         wdata_l    <= '0;
         rdata      <= '0;
         err        <= 1'b0;
      end else begin
         if (state == IDLE && grant) begin
            sel        <= gsel;
            we_l       <= gsel ? we1 : we0;
            addr_l     <= gaddr;
            wdata_l    <= gsel ? wdata1 : wdata0;
            last_grant <= gsel;
            oor        <= (gaddr >= LIMIT);
         end
         if (state == ACCESS) begin
            rdata <= (!oor && !we_l) ? mem_rdata : '0;
            err   <= oor;
         end
      end
   end

   always_comb begin
      ack0        = 1'b0;
      ack1        = 1'b0;
      busy        = 1'b0;
      mem_ena     = 1'b0;
      mem_wsignal = 1'b0;
      mem_rsignal = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      unique case (state)
         ACCESS: begin
            busy        = 1'b1;
            mem_addr    = addr_l;
            mem_wdata   = wdata_l;
            mem_ena     = !oor;
            mem_wsignal = !oor && we_l;
            mem_rsignal = !oor && !we_l;
         end
         DONE: begin
            busy = 1'b1;
            ack0 = !sel;
            ack1 = sel;
         end
         default: ;
      endcase
   end

endmodule
